shift_seq_ctrl: RTL

Sequencer and arbiter that shares one n-bit load/store shift register (ctrl 00 hold, 01 load, 10 left, 11 right; 3-bit per-cycle shift count, max 7) between two requesters, A and B.
It accepts load/shift commands, arbitrates round-robin, and splits shift amounts larger than 7 into per-cycle chunks. It drives the shift register's control pins and returns the final register value with a done pulse.
It sits between the accumulator datapath's control logic and the shift register instance.

---
 rtl/shift_seq_ctrl_pkg.sv | 44 ++++
 rtl/shift_seq_ctrl_if.sv | 55 +++++
 rtl/shift_seq_ctrl_rr_arb2.sv | 40 ++++
 rtl/shift_seq_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/shift_seq_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : shift_seq_pkg                                          |
// | Description : Shared constants and types for the shift-register      |
// |               sequencer (opcodes, shifter ctrl codes, FSM states).   |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
package shift_seq_pkg;

  // Requester opcodes
  localparam logic [1:0] OP_LOAD  = 2'b00;  // load only
  localparam logic [1:0] OP_LSH   = 2'b01;  // load then shift left
  localparam logic [1:0] OP_RSH   = 2'b10;  // load then shift right
  localparam logic [1:0] OP_SHIFT = 2'b11;  // shift stored value left

  // Shift register ctrl pin encodings
  localparam logic [1:0] SH_HOLD  = 2'b00;
  localparam logic [1:0] SH_LOAD  = 2'b01;
  localparam logic [1:0] SH_LEFT  = 2'b10;
  localparam logic [1:0] SH_RIGHT = 2'b11;

  // The shifter's num_shift pin is 3 bits wide, so one cycle moves at most 7
  localparam int NUM_W    = 3;
  localparam int MAX_STEP = 7;

  // Requester identifiers (also the last_grant encoding)
  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Largest chunk that can be issued this cycle out of the remaining amount
  function automatic logic [NUM_W-1:0] clip_step(input int unsigned rem);
    if (rem > MAX_STEP) return NUM_W'(MAX_STEP);
    else                return NUM_W'(rem);
  endfunction

endpackage
`default_nettype wire

// File: rtl/shift_seq_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : shift_seq_ctrl_if                                      |
// | Description : Requester-side command/response bundle for the         |
// |               shift sequencer. ROTATE_EN adds rot_a / rot_b.         |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
interface shift_seq_ctrl_if #(
  parameter int N     = 8,
  parameter int AMT_W = 4
);
  logic             req_a;
  logic [1:0]       op_a;
  logic [N-1:0]     data_a;
  logic [AMT_W-1:0] amt_a;
  logic             fill_a;
  logic             req_b;
  logic [1:0]       op_b;
  logic [N-1:0]     data_b;
  logic [AMT_W-1:0] amt_b;
  logic             fill_b;
`ifdef ROTATE_EN
  logic             rot_a;
  logic             rot_b;
`endif
  logic             gnt_a;
  logic             gnt_b;
  logic             busy;
  logic             done;
  logic             done_id;
  logic [N-1:0]     result;

  // Requester side
  modport master (
`ifdef ROTATE_EN
    output rot_a, output rot_b,
`endif
    output req_a, output op_a, output data_a, output amt_a, output fill_a,
    output req_b, output op_b, output data_b, output amt_b, output fill_b,
    input  gnt_a, input gnt_b, input busy, input done, input done_id,
    input  result
  );

  // Sequencer side
  modport slave (
`ifdef ROTATE_EN
    input  rot_a, input rot_b,
`endif
    input  req_a, input op_a, input data_a, input amt_a, input fill_a,
    input  req_b, input op_b, input data_b, input amt_b, input fill_b,
    output gnt_a, output gnt_b, output busy, output done, output done_id,
    output result
  );
endinterface
`default_nettype wire

// File: rtl/shift_seq_ctrl_rr_arb2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : rr_arb2                                                |
// | Description : Two-way round-robin arbiter. Grants are combinational  |
// |               and only issued while en=1; last_grant resets to B so  |
// |               A wins the first contested round.                      |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module rr_arb2
  import shift_seq_pkg::*;
(
  input  wire  clk,
  input  wire  rst,
  input  wire  en,
  input  wire  req_a,
  input  wire  req_b,
  output logic gnt_a,
  output logic gnt_b
);

  logic last_q;
  logic last_d;

  // Lone requester wins; on contention the one not granted last time wins
  always_comb begin
    gnt_a  = en && req_a && (!req_b || (last_q == ID_B));
    gnt_b  = en && req_b && (!req_a || (last_q == ID_A));
    last_d = last_q;
    if (gnt_a)      last_d = ID_A;
    else if (gnt_b) last_d = ID_B;
  end

  // Remember who was served last
  always_ff @(posedge clk) begin
    if (rst) last_q <= ID_B;
    else     last_q <= last_d;
  end

endmodule
`default_nettype wire

// File: rtl/shift_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : shift_seq_ctrl                                         |
// | Description : Shares one load/store shift register between two       |
// |               requesters. Arbitrates, loads, splits long shifts into |
// |               <=7-bit chunks and returns the final value with done.  |
// |               Optional macro ROTATE_EN: per-command rotate mode.     |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int N     = 8,
  parameter int AMT_W = 4
)(
  input  wire              clk,
  input  wire              rst,
  shift_seq_ctrl_if.slave  bus,
  output logic             sh_clr_n,
  output logic             sh_set_n,
  output logic [1:0]       sh_ctrl,
  output logic [NUM_W-1:0] sh_num,
  output logic             sh_ls,
  output logic             sh_rs,
  output logic [N-1:0]     sh_in,
  input  wire  [N-1:0]     sh_q
);

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [N-1:0]     data_q, data_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic             fill_q, fill_d;
  logic             id_q, id_d;
  logic [N-1:0]     result_q, result_d;
  logic             done_q, done_d;
  logic             done_id_q, done_id_d;
`ifdef ROTATE_EN
  logic             rot_q, rot_d;
`endif

  logic             gnt_a;
  logic             gnt_b;
  logic [NUM_W-1:0] step;
  logic             shift_left;
  logic             fill_bit;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .en    ((state_q == ST_IDLE) && !rst),
    .req_a (bus.req_a),
    .req_b (bus.req_b),
    .gnt_a (gnt_a),
    .gnt_b (gnt_b)
  );

  assign bus.gnt_a   = gnt_a;
  assign bus.gnt_b   = gnt_b;
  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.done    = done_q;
  assign bus.done_id = done_id_q;
  assign bus.result  = result_q;

  // Rotate mode moves one bit per cycle so the wrapped-in bit is always current
`ifdef ROTATE_EN
  assign step     = rot_q ? NUM_W'(1) : clip_step(32'(rem_q));
  assign fill_bit = rot_q ? (shift_left ? sh_q[N-1] : sh_q[0]) : fill_q;
`else
  assign step     = clip_step(32'(rem_q));
  assign fill_bit = fill_q;
`endif

  // Only op 10 shifts right; op 11 always shifts the stored value left
  assign shift_left = (op_q != OP_RSH);

  // State and command registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_LOAD;
      data_q    <= '0;
      rem_q     <= '0;
      fill_q    <= 1'b0;
      id_q      <= ID_A;
      result_q  <= '0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
`ifdef ROTATE_EN
      rot_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      data_q    <= data_d;
      rem_q     <= rem_d;
      fill_q    <= fill_d;
      id_q      <= id_d;
      result_q  <= result_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
`ifdef ROTATE_EN
      rot_q     <= rot_d;
`endif
    end
  end

  // Next state, command capture on grant, chunk bookkeeping and result capture
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    data_d    = data_q;
    rem_d     = rem_q;
    fill_d    = fill_q;
    id_d      = id_q;
    result_d  = result_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;
`ifdef ROTATE_EN
    rot_d     = rot_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (gnt_a || gnt_b) begin
          op_d   = gnt_b ? bus.op_b   : bus.op_a;
          data_d = gnt_b ? bus.data_b : bus.data_a;
          rem_d  = gnt_b ? bus.amt_b  : bus.amt_a;
          fill_d = gnt_b ? bus.fill_b : bus.fill_a;
          id_d   = gnt_b ? ID_B       : ID_A;
`ifdef ROTATE_EN
          rot_d  = gnt_b ? bus.rot_b  : bus.rot_a;
`endif
          if (op_d != OP_SHIFT) state_d = ST_LOAD;
          else if (rem_d != '0) state_d = ST_SHIFT;
          else                  state_d = ST_DONE;
        end
      end
      ST_LOAD: begin
        state_d = ((op_q == OP_LOAD) || (rem_q == '0)) ? ST_DONE : ST_SHIFT;
      end
      ST_SHIFT: begin
        rem_d   = rem_q - AMT_W'(step);
        state_d = (rem_d != '0) ? ST_SHIFT : ST_DONE;
      end
      ST_DONE: begin
        // Shifter output is final here; done is seen one cycle later in IDLE
        result_d  = sh_q;
        done_d    = 1'b1;
        done_id_d = id_q;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Shifter control pins decoded straight from state and command registers
  always_comb begin
    sh_clr_n = !rst;
    sh_set_n = 1'b1;
    sh_ctrl  = SH_HOLD;
    sh_num   = '0;
    sh_ls    = 1'b0;
    sh_rs    = 1'b0;
    sh_in    = '0;
    case (state_q)
      ST_LOAD: begin
        sh_ctrl = SH_LOAD;
        sh_in   = data_q;
      end
      ST_SHIFT: begin
        sh_ctrl = shift_left ? SH_LEFT : SH_RIGHT;
        sh_num  = step;
        sh_ls   = shift_left  && fill_bit;
        sh_rs   = !shift_left && fill_bit;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire
